// File: rtl/and16_if.sv
// -----------------------------------------------------------------------------
// and16_if -- streaming handshake bundle for the registered AND unit.
//
// Purpose : groups the operand/result valid-ready channels so producers,
//           consumers and the unit share one connection point.
//
// Signals :
//   in_valid   producer -> unit   a/b carry a valid operand pair
//   in_ready   unit -> producer   unit can take an operand pair this cycle
//   a, b       producer -> unit   operands, WIDTH bits
//   out_valid  unit -> consumer   out carries a valid result
//   out_ready  consumer -> unit   consumer takes the result this cycle
//   out        unit -> consumer   registered a & b, WIDTH bits
//   out_zero, out_ones, out_popcnt  (only with AND16_STATUS_EN defined)
//
// Modports : slave  = the AND unit itself
//            master = the environment driving operands / taking results
// -----------------------------------------------------------------------------
interface and16_if #(
    parameter int WIDTH = 16
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
`ifdef AND16_STATUS_EN
    logic             out_zero;
    logic             out_ones;
    logic [CNT_W-1:0] out_popcnt;
`endif

    modport slave (
        input  in_valid,
        output in_ready,
        input  a,
        input  b,
        output out_valid,
        input  out_ready,
        output out
`ifdef AND16_STATUS_EN
        ,
        output out_zero,
        output out_ones,
        output out_popcnt
`endif
    );

    modport master (
        output in_valid,
        input  in_ready,
        output a,
        output b,
        input  out_valid,
        output out_ready,
        input  out
`ifdef AND16_STATUS_EN
        ,
        input  out_zero,
        input  out_ones,
        input  out_popcnt
`endif
    );

endinterface

// File: rtl/and16_unit.sv
// -----------------------------------------------------------------------------
// and16_unit -- registered WIDTH-bit bitwise AND with valid/ready handshake.
//
// Purpose : accepts an operand pair (a, b) and presents out = a & b one clock
//           later. A single result register holds the value under
//           backpressure; a new pair may enter on the same edge the held
//           result leaves, giving one result per cycle.
//
// Ports :
//   clk   rising-edge clock
//   rst   synchronous, active-high reset (drops any pending result)
//   bus   and16_if.slave: in_valid/in_ready/a/b in, out_valid/out_ready/out
//
// Build option : define AND16_STATUS_EN to add out_zero, out_ones and
//                out_popcnt, registered alongside out and updated on accept.
// -----------------------------------------------------------------------------
module and16_unit #(
    parameter int WIDTH = 16
) (
    input  logic   clk,
    input  logic   rst,
    and16_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic             in_ready;
    logic             accept;
    logic             consume;
    logic [WIDTH-1:0] and_res;

    logic [WIDTH-1:0] out_d,       out_q;
    logic             out_valid_d, out_valid_q;

    // Ready depends only on the result register and downstream ready, never
    // on in_valid, so no combinational loop through a producer is possible.
    assign in_ready     = !out_valid_q || bus.out_ready;
    assign bus.in_ready = in_ready;

    always_comb begin
        // NOTE: every signal gets a default before any branch; a path that
        // leaves a combinational output unassigned infers a latch.
        and_res     = bus.a & bus.b;
        accept      = bus.in_valid && in_ready;
        consume     = out_valid_q && bus.out_ready;
        out_d       = out_q;
        out_valid_d = out_valid_q;

        if (accept) begin
            // Covers the simultaneous consume case too: the new result
            // replaces the old one and valid stays high.
            out_d       = and_res;
            out_valid_d = 1'b1;
        end else if (consume) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments so every flop samples
        // pre-edge values regardless of statement order.
        if (rst) begin
            // NOTE: the result register is cleared as well as the valid flag;
            // it is a single word, and a known value after reset is cheap.
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out       = out_q;

`ifdef AND16_STATUS_EN
    // Status flags describe the held result, so they load only on accept.
    logic             zero_d,   zero_q;
    logic             ones_d,   ones_q;
    logic [CNT_W-1:0] popcnt_d, popcnt_q;
    logic [CNT_W-1:0] res_cnt;

    always_comb begin
        res_cnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            res_cnt = res_cnt + CNT_W'(and_res[i]);
        end

        zero_d   = zero_q;
        ones_d   = ones_q;
        popcnt_d = popcnt_q;
        if (accept) begin
            zero_d   = ~|and_res;
            ones_d   = &and_res;
            popcnt_d = res_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // Matches the cleared result register: zero word, no ones.
            zero_q   <= 1'b1;
            ones_q   <= 1'b0;
            popcnt_q <= '0;
        end else begin
            zero_q   <= zero_d;
            ones_q   <= ones_d;
            popcnt_q <= popcnt_d;
        end
    end

    assign bus.out_zero   = zero_q;
    assign bus.out_ones   = ones_q;
    assign bus.out_popcnt = popcnt_q;
`endif

endmodule

// File: tb/tb_and16_unit.sv
// -----------------------------------------------------------------------------
// tb_and16_unit -- self-checking bench for and16_unit.
//
// Directed scenarios plus a randomized stream. The reference model is a
// one-entry queue of pending results plus the last accepted value; expected
// outputs come from that model. Status outputs are checked when the bench is
// compiled with AND16_STATUS_EN.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_and16_unit;
    localparam int WIDTH = 16;
    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    and16_if #(.WIDTH(WIDTH)) bus ();

    and16_unit #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: results waiting for the consumer, and the value the
    // result register last loaded (what out shows while nothing is pending).
    logic [WIDTH-1:0] pend_q[$];
    logic [WIDTH-1:0] last_out = '0;

    function automatic logic model_in_ready();
        return (pend_q.size() == 0) || (bus.out_ready === 1'b1);
    endfunction

    // Advance one clock and apply the handshake rules to the model using the
    // inputs that were stable before the edge; outputs are read 1ns later.
    task automatic tick();
        logic acc;
        @(posedge clk);
        acc = (bus.in_valid === 1'b1) && model_in_ready();
        if (rst) begin
            pend_q.delete();
            last_out = '0;
        end else begin
            if (pend_q.size() != 0 && bus.out_ready === 1'b1) void'(pend_q.pop_front());
            if (acc) begin
                pend_q.push_back(bus.a & bus.b);
                last_out = bus.a & bus.b;
            end
        end
        #1;
    endtask

    task automatic drive(input logic v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic ordy);
        bus.in_valid  = v;
        bus.a         = a;
        bus.b         = b;
        bus.out_ready = ordy;
    endtask

    task automatic test_reset();
        drive(1'b1, 16'h5A5A, 16'hFFFF, 1'b0);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid);
        end
        checks++;
        if (bus.out !== 16'h0000) begin
            errors++; $display("FAIL reset_out got=%h exp=0000", bus.out);
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready);
        end
`ifdef AND16_STATUS_EN
        checks++;
        if (bus.out_zero !== 1'b1 || bus.out_ones !== 1'b0 || bus.out_popcnt !== '0) begin
            errors++; $display("FAIL reset_status got=%b%b/%0d exp=10/0",
                               bus.out_zero, bus.out_ones, bus.out_popcnt);
        end
`endif
    endtask

    task automatic test_zero_result();
        drive(1'b1, 16'hFFFF, 16'h0000, 1'b1);
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out !== 16'h0000) begin
            errors++; $display("FAIL zero_result got=%b/%h exp=1/0000", bus.out_valid, bus.out);
        end
`ifdef AND16_STATUS_EN
        checks++;
        if (bus.out_zero !== 1'b1 || bus.out_popcnt !== CNT_W'(0)) begin
            errors++; $display("FAIL zero_status got=%b/%0d exp=1/0", bus.out_zero, bus.out_popcnt);
        end
`endif
        tick();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL zero_drain got=%b exp=0", bus.out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] ea[2] = '{16'hAAAA, 16'hCCCC};
        logic [WIDTH-1:0] eb[2] = '{16'hFFFF, 16'hAAAA};
        logic [WIDTH-1:0] er[2] = '{16'hAAAA, 16'h8888};
        int               ep[2] = '{8, 4};
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, ea[i], eb[i], 1'b1);
            tick();
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out !== er[i]) begin
                errors++; $display("FAIL b2b_%0d got=%b/%h exp=1/%h", i, bus.out_valid, bus.out, er[i]);
            end
`ifdef AND16_STATUS_EN
            checks++;
            if (bus.out_popcnt !== CNT_W'(ep[i])) begin
                errors++; $display("FAIL b2b_popcnt_%0d got=%0d exp=%0d", i, bus.out_popcnt, ep[i]);
            end
`endif
        end
        bus.in_valid = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        drive(1'b1, 16'hAAAA, 16'hFFFF, 1'b0);
        tick();
        drive(1'b1, 16'h1234, 16'hFFFF, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (bus.in_ready !== 1'b0) begin
                errors++; $display("FAIL stall_in_ready_%0d got=%b exp=0", i, bus.in_ready);
            end
            tick();
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out !== 16'hAAAA) begin
                errors++; $display("FAIL stall_hold_%0d got=%b/%h exp=1/aaaa", i, bus.out_valid, bus.out);
            end
        end
        bus.out_ready = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL release_in_ready got=%b exp=1", bus.in_ready);
        end
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out !== 16'h1234) begin
            errors++; $display("FAIL release_next got=%b/%h exp=1/1234", bus.out_valid, bus.out);
        end
        tick();
    endtask

    task automatic test_reset_mid_stall();
        drive(1'b1, 16'hCCCC, 16'hAAAA, 1'b0);
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out !== 16'h8888) begin
            errors++; $display("FAIL midstall_load got=%b/%h exp=1/8888", bus.out_valid, bus.out);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out !== 16'h0000) begin
            errors++; $display("FAIL midstall_reset got=%b/%h exp=0/0000", bus.out_valid, bus.out);
        end
        bus.out_ready = 1'b1;
        tick();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL midstall_no_deliver got=%b exp=0", bus.out_valid);
        end
    endtask

    task automatic test_all_ones();
        drive(1'b1, 16'hFFFF, 16'hFFFF, 1'b1);
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out !== 16'hFFFF) begin
            errors++; $display("FAIL all_ones got=%b/%h exp=1/ffff", bus.out_valid, bus.out);
        end
`ifdef AND16_STATUS_EN
        checks++;
        if (bus.out_ones !== 1'b1 || bus.out_zero !== 1'b0 || bus.out_popcnt !== CNT_W'(16)) begin
            errors++; $display("FAIL all_ones_status got=%b%b/%0d exp=01/16",
                               bus.out_zero, bus.out_ones, bus.out_popcnt);
        end
`endif
        tick();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            drive(1'($urandom_range(0, 3) != 0), WIDTH'($urandom), WIDTH'($urandom),
                  1'($urandom_range(0, 2) != 0));
            rst = ($urandom_range(0, 39) == 0);
            #1;
            checks++;
            if (bus.in_ready !== model_in_ready()) begin
                errors++; $display("FAIL rand_in_ready_%0d got=%b exp=%b", n, bus.in_ready, model_in_ready());
            end
            tick();
            checks++;
            if (bus.out_valid !== (pend_q.size() != 0)) begin
                errors++; $display("FAIL rand_out_valid_%0d got=%b exp=%b", n, bus.out_valid, pend_q.size() != 0);
            end
            checks++;
            if (bus.out !== last_out) begin
                errors++; $display("FAIL rand_out_%0d got=%h exp=%h", n, bus.out, last_out);
            end
`ifdef AND16_STATUS_EN
            checks++;
            if (bus.out_zero !== (last_out == '0) || bus.out_ones !== (last_out == '1) ||
                bus.out_popcnt !== CNT_W'($countones(last_out))) begin
                errors++; $display("FAIL rand_status_%0d got=%b%b/%0d exp=%b%b/%0d", n,
                                   bus.out_zero, bus.out_ones, bus.out_popcnt,
                                   last_out == '0, last_out == '1, $countones(last_out));
            end
`endif
        end
        rst = 1'b0;
    endtask

    initial begin
        drive(1'b0, '0, '0, 1'b1);
        #2;
        test_reset();
        test_zero_result();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_stall();
        test_all_ones();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
